dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 81 ++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory slave; define DMEM_ADDR_CHECK_EN to add addr_err range checking
module dmem_responder #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall
`ifdef DMEM_ADDR_CHECK_EN
    ,
    output logic        addr_err
`endif
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          lat_wr;
    logic [31:0]   word;
    logic [AW-1:0] idx;
    logic          bad;
    logic          commit;
    logic [31:0]   mem [DEPTH];
    assign word = (lat_addr - BASE_ADDR) >> 2;
`ifdef DMEM_ADDR_CHECK_EN
    assign bad      = (lat_addr < BASE_ADDR) || (word >= DEPTH_W);
    assign idx      = AW'(word);
    assign addr_err = ready & bad;
`else
    assign bad = 1'b0;
    assign idx = AW'(word % DEPTH_W);
`endif
    assign ready  = state == DONE;
    assign stall  = (mem_read | mem_write) & ~ready;
    assign commit = ready & lat_wr & ~bad;
    // access sequencer: latch request in IDLE, count wait states, complete in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rdata     <= 32'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_wr    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mem_read | mem_write) begin
                    lat_addr  <= addr;
                    lat_wdata <= wdata;
                    lat_wr    <= mem_write;
                    cnt       <= WC;
                    state     <= (WC == 4'd0) ? DONE : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) state <= DONE;
                end
                DONE: begin
                    if (!lat_wr) rdata <= bad ? 32'd0 : mem[idx];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // storage array is deliberately not reset; writes land only on a completed access
    always_ff @(posedge clk) begin
        if (commit) mem[idx] <= lat_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table-driven bench for dmem_responder
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata, rdata0;
    logic        ready, stall, ready0, stall0;
`ifdef DMEM_ADDR_CHECK_EN
    logic        addr_err, addr_err0;
`endif
    int checks = 0;
    int errors = 0;
    logic last_err = 1'b0;

    always #5 clk = ~clk;

    dmem_responder u2 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .stall(stall)
`ifdef DMEM_ADDR_CHECK_EN
        , .addr_err(addr_err)
`endif
    );

    dmem_responder #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .stall(stall0)
`ifdef DMEM_ADDR_CHECK_EN
        , .addr_err(addr_err0)
`endif
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one access on the WAIT_CYCLES=2 instance: latency, stall shape, single-cycle ready
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input string nm);
        int k;
        @(negedge clk);
        mem_read = r; mem_write = w; addr = a; wdata = d;
        #1 chk(32'(stall), 32'd1, {nm, " stall_first"});
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!ready && stall !== 1'b1) chk(32'(stall), 32'd1, {nm, " stall_wait"});
        end while (!ready && k < 20);
        chk(k, 32'd3, {nm, " latency"});
        chk(32'(stall), 32'd0, {nm, " stall_ready"});
`ifdef DMEM_ADDR_CHECK_EN
        last_err = addr_err;
`endif
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk(32'(ready), 32'd0, {nm, " ready_width"});
    endtask

    // one access on the zero-wait instance
    task automatic access0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int k;
        @(negedge clk);
        mem_read = r; mem_write = w; addr = a; wdata = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready0 && k < 10);
        chk(k, 32'd1, "w0 latency");
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[11];

    initial begin
        int k;
        logic seen;
        vecs[0]  = '{0, 1, 32'd1024, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1, 0, 32'd1024, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1, 1, 32'd1028, 32'h5,        32'hDEADBEEF};
        vecs[3]  = '{1, 0, 32'd1028, 32'h0,        32'h5};
        vecs[4]  = '{0, 1, 32'd1036, 32'h12345678, 32'h5};
        vecs[5]  = '{1, 0, 32'd1036, 32'h0,        32'h12345678};
        vecs[6]  = '{0, 1, 32'd1024, 32'hCAFEF00D, 32'h12345678};
        vecs[7]  = '{1, 0, 32'd1024, 32'h0,        32'hCAFEF00D};
        vecs[8]  = '{0, 1, 32'd1276, 32'hA5A5A5A5, 32'hCAFEF00D};
        vecs[9]  = '{1, 0, 32'd1276, 32'h0,        32'hA5A5A5A5};
        vecs[10] = '{1, 0, 32'd1028, 32'h0,        32'h5};

        #2;
        chk(rdata, 32'd0, "reset rdata");
        chk(32'(ready), 32'd0, "reset ready");
        chk(32'(stall), 32'd0, "reset stall");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk(32'(ready), 32'd0, "idle ready");

        for (int i = 0; i < 11; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, $sformatf("vec%0d", i));
            chk(rdata, vecs[i].exp_rdata, $sformatf("vec%0d rdata", i));
        end

        access(1'b0, 1'b1, 32'd1280, 32'h0BAD0BAD, "alias_wr");
        access(1'b1, 1'b0, 32'd1024, 32'h0, "alias_rd");
`ifdef DMEM_ADDR_CHECK_EN
        chk(32'(last_err), 32'd0, "inrange addr_err");
        access(1'b0, 1'b1, 32'd1280, 32'h0BAD0BAD, "oob_wr");
        chk(32'(last_err), 32'd1, "oob addr_err");
        access(1'b1, 1'b0, 32'd1024, 32'h0, "oob_chk");
        chk(rdata, 32'hCAFEF00D, "oob memory unchanged");
`else
        chk(rdata, 32'h0BAD0BAD, "alias to index 0");
`endif

        @(negedge clk);
        mem_write = 1'b1; addr = 32'd1040; wdata = 32'h11;
        @(negedge clk);
        addr = 32'd1044; wdata = 32'h99; mem_read = 1'b1;
        k = 0;
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(k, 32'd2, "latched latency");
        mem_read = 1'b0; mem_write = 1'b0;
        access(1'b1, 1'b0, 32'd1040, 32'h0, "latched_rd");
        chk(rdata, 32'h11, "latched inputs used");

        access(1'b0, 1'b1, 32'd1032, 32'h1111, "pre_wr");
        @(negedge clk);
        mem_write = 1'b1; addr = 32'd1032; wdata = 32'h2222;
        @(negedge clk);
        rst = 1'b0;
        #1 chk(rdata, 32'd0, "abort rdata");
        chk(32'(ready), 32'd0, "abort ready");
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= ready;
        end
        chk(32'(seen), 32'd0, "abort no ready");
        access(1'b1, 1'b0, 32'd1032, 32'h0, "abort_rd");
        chk(rdata, 32'h1111, "abort no commit");

        repeat (4) @(negedge clk);
        access0(1'b0, 1'b1, 32'd1024, 32'h1234);
        access0(1'b0, 1'b1, 32'd1028, 32'h5678);
        repeat (4) @(negedge clk);
        mem_read = 1'b1; addr = 32'd1024;
        @(negedge clk);
        chk(32'(ready0), 32'd1, "b2b ready first");
        addr = 32'd1028;
        @(negedge clk);
        chk(32'(ready0), 32'd0, "b2b gap");
        chk(32'(stall0), 32'd1, "b2b stall");
        chk(rdata0, 32'h1234, "b2b rdata first");
        @(negedge clk);
        chk(32'(ready0), 32'd1, "b2b ready second");
        mem_read = 1'b0;
        @(negedge clk);
        chk(32'(ready0), 32'd0, "b2b end");
        chk(rdata0, 32'h5678, "b2b rdata second");
`ifdef DMEM_ADDR_CHECK_EN
        chk(32'(addr_err0), 32'd0, "w0 addr_err");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
